// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of one single-port block SRAM with a 1-cycle read latency.
// Port 0 (pixel fetcher) has fixed priority. Port 1 (game logic) may read or write.
// A starvation guard forces a port-1 grant after MAX_WAIT consecutive denied cycles.
module sram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 8   // legal range 1..255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // port 0: read-only, high priority
  input  logic                  p0_valid,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_ready,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  // port 1: read/write, low priority with starvation guard
  input  logic                  p1_valid,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ready,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  // SRAM side
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam logic [7:0] WaitMax = 8'(MAX_WAIT);

  logic       g0;
  logic       g1;
  logic [7:0] wait_q, wait_d;
  logic       force_q, force_d;
  logic       p0_rvalid_q;
  logic       p1_rvalid_q;

  // Same-cycle grant. Grants are qualified by reset_n so the SRAM enable and
  // both ready strobes drop the moment reset asserts, not at the next edge.
  always_comb begin
    g1 = reset_n & p1_valid & (force_q | ~p0_valid);
    g0 = reset_n & p0_valid & ~g1;
  end

  assign p0_ready   = g0;
  assign p1_ready   = g1;

  assign sram_en    = g0 | g1;
  assign sram_we    = g1 & p1_we;
  assign sram_addr  = g1 ? p1_addr : p0_addr;
  assign sram_wdata = p1_wdata;

  // Starvation guard next state: count denied port-1 cycles, force a grant at the limit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wait_d  = wait_q;
    force_d = force_q;
    if (g1 || !p1_valid) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + 8'd1;
    end
    // force is raised on the same edge the counter reaches the limit, so the
    // grant lands after exactly MAX_WAIT denied cycles.
    if (g1) begin
      force_d = 1'b0;
    end else if (wait_d == WaitMax) begin
      force_d = 1'b1;
    end
  end

  // Guard state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      wait_q  <= '0;
      force_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      force_q <= force_d;
    end
  end

  // Read-valid strobes, aligned with the SRAM's registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      p0_rvalid_q <= g0;
      p1_rvalid_q <= g1 & ~p1_we;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;

  // Read data is a passthrough, forced to zero only while reset is held.
  assign p0_rdata = reset_n ? sram_rdata : '0;
  assign p1_rdata = reset_n ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, read-data scoreboard,
// a table of single-cycle vectors and hand-written multi-cycle sequences.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_valid, p0_ready, p0_rvalid;
  logic [15:0] p0_addr;
  logic [7:0]  p0_rdata;
  logic        p1_valid, p1_we, p1_ready, p1_rvalid;
  logic [15:0] p1_addr;
  logic [7:0]  p1_wdata, p1_rdata;
  logic        sram_en, sram_we;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata = 8'hFF;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem     [0:65535];  // SRAM contents
  logic [7:0] ref_mem [0:65535];  // bench reference for expected data
  logic [7:0] q0 [$];             // expected port-0 read data
  logic [7:0] q1 [$];             // expected port-1 read data

  sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MAX_WAIT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_ready(p0_ready),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM with registered read data.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response checker: one cycle after each read grant the matching rvalid must
  // be high with the expected data; rvalid at any other time is an error.
  always @(negedge clk) begin
    if (reset_n) begin
      if (p0_rvalid) begin
        if (q0.size() == 0) check("p0_unexpected_rvalid", 1, 0);
        else                check("p0_rdata", {24'd0, p0_rdata}, {24'd0, q0.pop_front()});
      end else if (q0.size() != 0) begin
        check("p0_missing_rvalid", 0, 1);
        void'(q0.pop_front());
      end
      if (p1_rvalid) begin
        if (q1.size() == 0) check("p1_unexpected_rvalid", 1, 0);
        else                check("p1_rdata", {24'd0, p1_rdata}, {24'd0, q1.pop_front()});
      end else if (q1.size() != 0) begin
        check("p1_missing_rvalid", 0, 1);
        void'(q1.pop_front());
      end
    end
  end

  // Drive one cycle of stimulus after the falling edge and record expected results.
  task automatic cycle(input logic p0v, input logic [15:0] p0a, input logic p1v,
                       input logic p1w, input logic [15:0] p1a, input logic [7:0] p1d);
    @(negedge clk);
    p0_valid = p0v; p0_addr = p0a;
    p1_valid = p1v; p1_we = p1w; p1_addr = p1a; p1_wdata = p1d;
    #1;
    if (p0_valid && p0_ready) q0.push_back(ref_mem[p0_addr]);
    if (p1_valid && p1_ready) begin
      if (p1_we) ref_mem[p1_addr] = p1_wdata;
      else       q1.push_back(ref_mem[p1_addr]);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  typedef struct {
    string       name;
    logic        p0v;
    logic [15:0] p0a;
    logic        p1v;
    logic        p1w;
    logic [15:0] p1a;
    logic [7:0]  p1d;
    logic        e_r0;
    logic        e_r1;
    logic        e_en;
    logic        e_we;
    logic [15:0] e_addr;
  } vec_t;

  function automatic vec_t mk(string n, logic p0v, logic [15:0] p0a, logic p1v, logic p1w,
                              logic [15:0] p1a, logic [7:0] p1d, logic r0, logic r1,
                              logic en, logic we, logic [15:0] ea);
    vec_t v;
    v.name = n; v.p0v = p0v; v.p0a = p0a; v.p1v = p1v; v.p1w = p1w; v.p1a = p1a;
    v.p1d = p1d; v.e_r0 = r0; v.e_r1 = r1; v.e_en = en; v.e_we = we; v.e_addr = ea;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i]     = 8'h10 + 8'(i);
      ref_mem[i] = 8'h10 + 8'(i);
    end
    mem[16'h0010] = 8'h5A; ref_mem[16'h0010] = 8'h5A;
    mem[16'h0100] = 8'h00; ref_mem[16'h0100] = 8'h00;

    //                name          p0v p0a       p1v we p1a       wd     r0 r1 en we addr
    vecs[0] = mk("p0_read",         1, 16'h0010, 0, 0, 16'h0000, 8'h00, 1, 0, 1, 0, 16'h0010);
    vecs[1] = mk("idle",            0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 16'h0000);
    vecs[2] = mk("p1_write",        0, 16'h0000, 1, 1, 16'h0100, 8'h3C, 0, 1, 1, 1, 16'h0100);
    vecs[3] = mk("p1_read",         0, 16'h0000, 1, 0, 16'h0100, 8'h00, 0, 1, 1, 0, 16'h0100);
    vecs[4] = mk("both_p0_wins",    1, 16'h0010, 1, 0, 16'h0100, 8'h00, 1, 0, 1, 0, 16'h0010);
    vecs[5] = mk("p1_alone_again",  0, 16'h0000, 1, 0, 16'h0100, 8'h00, 0, 1, 1, 0, 16'h0100);
    vecs[6] = mk("idle_end",        0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 16'h0000);

    // Power-up reset.
    reset_n = 1'b0;
    p0_valid = 1'b0; p0_addr = '0; p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    #12;
    check("rst_p0_rvalid", p0_rvalid, 0);
    check("rst_p1_rvalid", p1_rvalid, 0);
    check("rst_p0_rdata",  p0_rdata, 0);
    check("rst_p1_rdata",  p1_rdata, 0);
    check("rst_sram_en",   sram_en, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven single-cycle vectors.
    foreach (vecs[i]) begin
      cycle(vecs[i].p0v, vecs[i].p0a, vecs[i].p1v, vecs[i].p1w, vecs[i].p1a, vecs[i].p1d);
      check({vecs[i].name, "_p0_ready"}, p0_ready, vecs[i].e_r0);
      check({vecs[i].name, "_p1_ready"}, p1_ready, vecs[i].e_r1);
      check({vecs[i].name, "_sram_en"},  sram_en,  vecs[i].e_en);
      check({vecs[i].name, "_sram_we"},  sram_we,  vecs[i].e_we);
      if (vecs[i].e_en) check({vecs[i].name, "_sram_addr"}, sram_addr, vecs[i].e_addr);
    end
    check("write_data_stored", mem[16'h0100], 8'h3C);

    // Contention: both valid for 20 cycles, port 1 forced through every 9th cycle.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'(i % 8), 1'b1, 1'b0, 16'h0010, 8'h00);
      check("cont_p1_ready", p1_ready, (i % 9) == 8);
      check("cont_p0_ready", p0_ready, (i % 9) != 8);
    end
    idle();

    // Port 1 withdraws after 5 denied cycles; the guard restarts on re-assert.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0100, 8'h00);
      check("drop_pre_p1_ready", p1_ready, 0);
    end
    cycle(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0100, 8'h00);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0100, 8'h00);
      check("drop_post_p1_ready", p1_ready, i == 8);
    end
    idle();

    // Streaming port-0 reads; the scoreboard checks order and back-to-back rvalid.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b0, 16'h0000, 8'h00);
      check("stream_p0_ready", p0_ready, 1);
    end
    idle();
    idle();

    // Async reset asserted mid-stream, between clock edges.
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
    cycle(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 8'h00);
    cycle(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    check("pre_rst_p0_rvalid", p0_rvalid, 1);
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check("mid_rst_p0_rvalid", p0_rvalid, 0);
    check("mid_rst_p1_rvalid", p1_rvalid, 0);
    check("mid_rst_sram_en",   sram_en, 0);
    check("mid_rst_p0_ready",  p0_ready, 0);
    check("mid_rst_p0_rdata",  p0_rdata, 0);
    check("mid_rst_p1_rdata",  p1_rdata, 0);
    p0_valid = 1'b0; p1_valid = 1'b0;
    @(negedge clk);
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post_rst_idle_en",     sram_en, 0);
      check("post_rst_idle_we",     sram_we, 0);
      check("post_rst_idle_ready",  {p0_ready, p1_ready}, 0);
      check("post_rst_idle_rvalid", {p0_rvalid, p1_rvalid}, 0);
    end

    // First contention after reset behaves as from power-up.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 16'h0004, 1'b1, 1'b0, 16'h0100, 8'h00);
      check("post_rst_p1_ready", p1_ready, i == 8);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
